// File: rtl/dbus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : dbus_xbar
// Brief    : NCORES x NTARGETS data-bus crossbar. Base/mask region decode,
//            per-target round-robin arbitration, registered read return path.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_xbar #(
    parameter int NCORES   = 2,
    parameter int NTARGETS = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [NTARGETS*ADDR_W-1:0] TGT_BASE =
        {32'h4000_1000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NTARGETS*ADDR_W-1:0] TGT_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000},
    parameter int CIDW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NCORES-1:0]            m_req_i,
    input  logic [NCORES-1:0]            m_we_i,
    input  logic [NCORES*ADDR_W-1:0]     m_addr_i,
    input  logic [NCORES*DATA_W-1:0]     m_wdata_i,
    input  logic [NCORES*DATA_W/8-1:0]   m_wstrb_i,
    output logic [NCORES-1:0]            m_stall_o,
    output logic [NCORES*DATA_W-1:0]     m_rdata_o,
    output logic [NCORES-1:0]            m_err_o,
    output logic [NTARGETS-1:0]          t_req_o,
    output logic [NTARGETS-1:0]          t_we_o,
    output logic [NTARGETS*ADDR_W-1:0]   t_addr_o,
    output logic [NTARGETS*DATA_W-1:0]   t_wdata_o,
    output logic [NTARGETS*DATA_W/8-1:0] t_wstrb_o,
    output logic [NTARGETS*CIDW-1:0]     t_src_o,
    input  logic [NTARGETS-1:0]          t_stall_i,
    input  logic [NTARGETS*DATA_W-1:0]   t_rdata_i
);

    localparam int c_strb_w = DATA_W / 8;
    localparam int c_tidw   = (NTARGETS > 1) ? $clog2(NTARGETS) : 1;

    logic [NCORES-1:0]   w_hit;
    logic [c_tidw-1:0]   w_tsel [NCORES];
    logic [CIDW-1:0]     w_win  [NTARGETS];
    logic [NCORES-1:0]   w_gnt;
    logic [NCORES-1:0]   w_acc;

    logic [CIDW-1:0]     r_rr   [NTARGETS];
    logic [NCORES-1:0]   r_rv;
    logic [c_tidw-1:0]   r_rsel [NCORES];
    logic [NCORES-1:0]   r_err;

    // Descending scan so the lowest-index matching region wins overlaps
    always_comb begin
        w_hit = '0;
        for (int m = 0; m < NCORES; m++) begin
            w_tsel[m] = '0;
            for (int t = NTARGETS - 1; t >= 0; t--) begin
                if ((m_addr_i[m*ADDR_W +: ADDR_W] & TGT_MASK[t*ADDR_W +: ADDR_W])
                        == TGT_BASE[t*ADDR_W +: ADDR_W]) begin
                    w_hit[m]  = 1'b1;
                    w_tsel[m] = c_tidw'(t);
                end
            end
        end
    end

    // Per-target round-robin: first requester at or after r_rr[t], modulo NCORES
    always_comb begin
        int h;
        h         = 0;
        t_req_o   = '0;
        t_we_o    = '0;
        t_addr_o  = '0;
        t_wdata_o = '0;
        t_wstrb_o = '0;
        t_src_o   = '0;
        for (int t = 0; t < NTARGETS; t++) begin
            w_win[t] = '0;
            for (int k = 0; k < NCORES; k++) begin
                h = (int'(r_rr[t]) + k) % NCORES;
                if (!t_req_o[t] && m_req_i[h] && w_hit[h] && (int'(w_tsel[h]) == t)) begin
                    t_req_o[t]                             = 1'b1;
                    w_win[t]                               = CIDW'(h);
                    t_we_o[t]                              = m_we_i[h];
                    t_addr_o[t*ADDR_W +: ADDR_W]           = m_addr_i[h*ADDR_W +: ADDR_W];
                    t_wdata_o[t*DATA_W +: DATA_W]          = m_wdata_i[h*DATA_W +: DATA_W];
                    t_wstrb_o[t*c_strb_w +: c_strb_w]      = m_wstrb_i[h*c_strb_w +: c_strb_w];
                    t_src_o[t*CIDW +: CIDW]                = CIDW'(h);
                end
            end
        end
    end

    always_comb begin
        w_gnt     = '0;
        w_acc     = '0;
        m_stall_o = '0;
        for (int m = 0; m < NCORES; m++) begin
            w_gnt[m]     = w_hit[m] && t_req_o[w_tsel[m]] && (w_win[w_tsel[m]] == CIDW'(m));
            w_acc[m]     = m_req_i[m] && w_gnt[m] && !t_stall_i[w_tsel[m]];
            m_stall_o[m] = m_req_i[m] && w_hit[m] && (!w_gnt[m] || t_stall_i[w_tsel[m]]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NTARGETS; t++) r_rr[t] <= '0;
        end else begin
            for (int t = 0; t < NTARGETS; t++) begin
                if (t_req_o[t] && !t_stall_i[t]) begin
                    r_rr[t] <= CIDW'((int'(w_win[t]) + 1) % NCORES);
                end
            end
        end
    end

    // Return path: a response only ever follows an accepted read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rv  <= '0;
            r_err <= '0;
            for (int m = 0; m < NCORES; m++) r_rsel[m] <= '0;
        end else begin
            r_rv  <= w_acc & ~m_we_i;
            r_err <= m_req_i & ~w_hit;
            for (int m = 0; m < NCORES; m++) begin
                if (w_acc[m]) r_rsel[m] <= w_tsel[m];
            end
        end
    end

    generate
        for (genvar m = 0; m < NCORES; m++) begin : g_ret
            assign m_rdata_o[m*DATA_W +: DATA_W] =
                r_rv[m] ? t_rdata_i[int'(r_rsel[m])*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    assign m_err_o = r_err;

endmodule
`default_nettype wire
